// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline definitions: stage state encoding and default payload widths.
package pipe_stage_reg_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_t;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_CTRL_W = 8;
    localparam int DEF_CNT_W  = 16;

    function automatic logic [1:0] state_occupancy(input stage_state_t s);
        case (s)
            ST_BUSY: return 2'd1;
            ST_FULL: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_reg_skid.sv
// Second storage slot of the stage; holds one {ctrl,data} entry while the main slot is stalled.
module pipe_stage_reg_skid #(
    parameter int W = 40
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (load)
            q <= d;
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with optional skid slot and stall counter.
//   state    | meaning
//   ST_EMPTY | no entry held
//   ST_BUSY  | one entry in the main slot
//   ST_FULL  | main slot plus skid slot occupied (SKID=1 only)
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int SKID   = 1,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int ENT_W = CTRL_W + DATA_W;

    stage_state_t      state, state_nxt;
    logic              accept, consume;
    logic              in_ready_q, in_ready_nxt;
    logic              load_main, load_skid, main_from_skid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [ENT_W-1:0]  skid_q;
    logic [CNT_W-1:0]  stall_q;

    assign out_valid = (state != ST_EMPTY);
    assign in_ready  = (SKID != 0) ? in_ready_q : (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_nxt;
            in_ready_q <= in_ready_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state_nxt = ST_BUSY;
                        load_main = 1'b1;
                    end
                end
                ST_BUSY: begin
                    case ({accept, consume})
                        2'b11: load_main = 1'b1;
                        2'b10: begin
                            state_nxt = ST_FULL;
                            load_skid = 1'b1;
                        end
                        2'b01: state_nxt = ST_EMPTY;
                        default: state_nxt = ST_BUSY;
                    endcase
                end
                ST_FULL: begin
                    // in_ready is low here, so only the drain path exists
                    if (consume) begin
                        state_nxt      = ST_BUSY;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_nxt = ST_EMPTY;
            endcase
        end
        in_ready_nxt = (state_nxt != ST_FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_ctrl <= '0;
            main_data <= '0;
        end else if (load_main) begin
            main_ctrl <= in_ctrl;
            main_data <= in_data;
        end else if (main_from_skid) begin
            main_ctrl <= skid_q[ENT_W-1:DATA_W];
            main_data <= skid_q[DATA_W-1:0];
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            pipe_stage_reg_skid #(.W(ENT_W)) u_skid (
                .clk  (clk),
                .rst  (rst),
                .load (load_skid),
                .d    ({in_ctrl, in_data}),
                .q    (skid_q)
            );
        end else begin : g_no_skid
            assign skid_q = '0;
        end
    endgenerate

    // Stall counting ignores flush so a kill never hides backpressure history
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_q <= '0;
        else if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}}))
            stall_q <= stall_q + 1'b1;
    end

    assign out_ctrl  = out_valid ? main_ctrl : '0;
    assign out_data  = main_data;
    assign occupancy = state_occupancy(state);
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: skid, saturating-counter and single-register variants against a queue model.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  in_ctrl = '0;
    logic [31:0] in_data = '0;

    always #5 clk = ~clk;

    logic        a_rdy, a_vld, b_rdy, b_vld, c_rdy, c_vld;
    logic [7:0]  a_ctrl, b_ctrl, c_ctrl;
    logic [31:0] a_data, b_data, c_data;
    logic [1:0]  a_occ, b_occ, c_occ;
    logic [15:0] a_stall, c_stall;
    logic [3:0]  b_stall;

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID(1), .CNT_W(16)) u_skid (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_rdy),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(a_vld), .out_ready(out_ready),
        .out_ctrl(a_ctrl), .out_data(a_data), .occupancy(a_occ), .stall_cnt(a_stall)
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID(1), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_rdy),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(b_vld), .out_ready(out_ready),
        .out_ctrl(b_ctrl), .out_data(b_data), .occupancy(b_occ), .stall_cnt(b_stall)
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID(0), .CNT_W(16)) u_reg (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(c_rdy),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(c_vld), .out_ready(out_ready),
        .out_ctrl(c_ctrl), .out_data(c_data), .occupancy(c_occ), .stall_cnt(c_stall)
    );

    logic        o_rdy [3];
    logic        o_vld [3];
    logic [7:0]  o_ctrl [3];
    logic [31:0] o_data [3];
    logic [1:0]  o_occ [3];
    logic [15:0] o_stall [3];

    always_comb begin
        o_rdy[0] = a_rdy;   o_rdy[1] = b_rdy;   o_rdy[2] = c_rdy;
        o_vld[0] = a_vld;   o_vld[1] = b_vld;   o_vld[2] = c_vld;
        o_ctrl[0] = a_ctrl; o_ctrl[1] = b_ctrl; o_ctrl[2] = c_ctrl;
        o_data[0] = a_data; o_data[1] = b_data; o_data[2] = c_data;
        o_occ[0] = a_occ;   o_occ[1] = b_occ;   o_occ[2] = c_occ;
        o_stall[0] = a_stall;
        o_stall[1] = {12'd0, b_stall};
        o_stall[2] = c_stall;
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Model: each instance is an in-order queue of {ctrl,data}; capacity 2 with skid, 1 without
    logic [39:0] m_buf [3][2];
    int          m_cnt [3];
    logic [31:0] m_data [3];
    int          m_stall [3];
    logic        m_rdy [3];
    int          m_max [3];

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0;
            m_data[i] = '0;
            m_stall[i] = 0;
            m_rdy[i] = 1'b1;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            bit acc, con;
            acc = in_valid && m_rdy[i];
            con = (m_cnt[i] > 0) && out_ready;
            if (m_cnt[i] > 0 && !out_ready && m_stall[i] < m_max[i])
                m_stall[i]++;
            if (flush) begin
                m_cnt[i] = 0;
            end else begin
                if (con) begin
                    m_buf[i][0] = m_buf[i][1];
                    m_cnt[i]--;
                end
                if (acc) begin
                    m_buf[i][m_cnt[i]] = {in_ctrl, in_data};
                    m_cnt[i]++;
                end
            end
            if (m_cnt[i] > 0)
                m_data[i] = m_buf[i][0][31:0];
            if (i < 2)
                m_rdy[i] = (m_cnt[i] < 2);
        end
    endtask

    task automatic check_outputs(input string ph);
        for (int i = 0; i < 3; i++) begin
            logic [7:0] ec;
            ec = (m_cnt[i] > 0) ? m_buf[i][0][39:32] : 8'h00;
            chk($sformatf("%s_valid%0d", ph, i), o_vld[i], m_cnt[i] > 0);
            chk($sformatf("%s_ctrl%0d", ph, i), o_ctrl[i], ec);
            chk($sformatf("%s_data%0d", ph, i), o_data[i], m_data[i]);
            chk($sformatf("%s_occ%0d", ph, i), o_occ[i], m_cnt[i]);
            chk($sformatf("%s_stall%0d", ph, i), o_stall[i], m_stall[i]);
        end
    endtask

    task automatic step(input string ph, input logic iv, input logic [7:0] c,
                        input logic [31:0] d, input logic ordy, input logic fl);
        in_valid = iv;
        in_ctrl = c;
        in_data = d;
        out_ready = ordy;
        flush = fl;
        m_rdy[2] = (m_cnt[2] == 0) || ordy;
        #1;
        for (int i = 0; i < 3; i++)
            chk($sformatf("%s_in_ready%0d", ph, i), o_rdy[i], m_rdy[i]);
        model_edge();
        @(posedge clk);
        #1;
        check_outputs(ph);
    endtask

    task automatic reset_pulse(input string ph);
        #2;
        rst = 1'b1;
        #1;
        chk({ph, "_valid"}, a_vld, 1'b0);
        chk({ph, "_ctrl"}, a_ctrl, 8'h00);
        chk({ph, "_occ"}, a_occ, 2'd0);
        chk({ph, "_in_ready"}, a_rdy, 1'b1);
        chk({ph, "_reg_valid"}, c_vld, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        logic [15:0] s0;
        m_max[0] = 65535;
        m_max[1] = 15;
        m_max[2] = 65535;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_outputs("reset");
        for (int i = 0; i < 3; i++)
            chk($sformatf("reset_in_ready%0d", i), o_rdy[i], 1'b1);

        // streaming with downstream always ready
        for (int k = 0; k < 8; k++) begin
            step("stream", 1'b1, 8'($urandom), 32'((k + 1) * 32'h11), 1'b1, 1'b0);
            chk("stream_const_data", a_data, 32'((k + 1) * 32'h11));
            chk("stream_const_valid", a_vld, 1'b1);
        end
        step("stream_end", 1'b0, 8'h00, 32'h0, 1'b1, 1'b0);
        chk("stream_const_stall", a_stall, 16'd0);

        // backpressure from one held entry
        step("bp_fill", 1'b1, 8'hA1, 32'hB001, 1'b1, 1'b0);
        s0 = a_stall;
        for (int k = 0; k < 3; k++)
            step("bp", 1'b1, 8'(8'hC0 + k), 32'(32'hC000 + k), 1'b0, 1'b0);
        chk("bp_stall_delta", 64'(a_stall - s0), 64'd3);
        chk("bp_occ", a_occ, 2'd2);
        chk("bp_in_ready", a_rdy, 1'b0);
        for (int k = 0; k < 3; k++)
            step("bp_drain", 1'b0, 8'h00, 32'h0, 1'b1, 1'b0);

        // flush with a simultaneous accept while full
        step("fl_fill", 1'b1, 8'hD1, 32'hD001, 1'b0, 1'b0);
        step("fl_fill", 1'b1, 8'hD2, 32'hD002, 1'b0, 1'b0);
        chk("fl_pre_occ", a_occ, 2'd2);
        step("flush", 1'b1, 8'hD3, 32'hD003, 1'b0, 1'b1);
        chk("flush_occ", a_occ, 2'd0);
        chk("flush_valid", a_vld, 1'b0);
        chk("flush_ctrl", a_ctrl, 8'h00);
        for (int k = 0; k < 3; k++)
            step("fl_after", 1'b0, 8'h00, 32'h0, 1'b1, 1'b0);

        // reset while full
        step("rf_fill", 1'b1, 8'hE1, 32'hE001, 1'b0, 1'b0);
        step("rf_fill", 1'b1, 8'hE2, 32'hE002, 1'b0, 1'b0);
        chk("rf_pre_occ", a_occ, 2'd2);
        reset_pulse("rst_full");
        check_outputs("rst_full_after");
        step("rf_first", 1'b1, 8'hE5, 32'hE005, 1'b0, 1'b0);
        chk("rf_first_data", a_data, 32'hE005);

        // counter saturation on the narrow-counter instance
        reset_pulse("rst_sat");
        step("sat_fill", 1'b1, 8'h5A, 32'h5A5A, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++)
            step("sat", 1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
        chk("sat_stop", b_stall, 4'd15);
        for (int k = 0; k < 3; k++)
            step("sat_drain", 1'b0, 8'h00, 32'h0, 1'b1, 1'b0);

        // alternating downstream ready while streaming
        for (int k = 0; k < 16; k++)
            step("alt", 1'b1, 8'(k + 1), 32'(32'hF00 + k), k[0], 1'b0);
        for (int k = 0; k < 3; k++)
            step("alt_drain", 1'b0, 8'h00, 32'h0, 1'b1, 1'b0);

        // random traffic
        for (int k = 0; k < 400; k++)
            step("rand", $urandom_range(0, 9) < 7, 8'($urandom), $urandom,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 29) == 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
